// File: rtl/fifo_port_sched_if.sv
// Handshake and Fifo-control bundle between the CPU/host I/O logic, the port scheduler and the Fifo.
// The slave modport is the scheduler's view; the master modport is the surrounding logic's view.
interface fifo_port_sched_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 13
);
  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              rd_req;
  logic              rd_valid;
  logic              flush_req;
  logic              flush_busy;
  logic              fifo_write;
  logic [DATA_W-1:0] fifo_din;
  logic              fifo_adv;
  logic              fifo_rst;
  logic [ADDR_W-1:0] count;
  logic              full;
  logic              empty;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, rd_req, flush_req,
    output a_ready, b_ready, rd_valid, flush_busy,
           fifo_write, fifo_din, fifo_adv, fifo_rst, count, full, empty
  );

  modport master (
    output a_valid, a_data, b_valid, b_data, rd_req, flush_req,
    input  a_ready, b_ready, rd_valid, flush_busy,
           fifo_write, fifo_din, fifo_adv, fifo_rst, count, full, empty
  );
endinterface

// File: rtl/fifo_port_sched.sv
// Round-robin write-port sharer, occupancy tracker and flush sequencer for one Fifo; accept->write 1 cycle, accept->poppable 3 cycles.
// Readys drop while full, flushing or in reset; pops limited to one every other cycle while data_out reloads.
module fifo_port_sched #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_port_sched_if.slave    bus
);
  typedef enum logic [1:0] {RUN, FLUSH, SETTLE} state_t;

  localparam logic [ADDR_W-1:0] CNT_MAX = '1;
  localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic              last_b_q, last_b_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              frst_q, frst_d;
  logic              wr_d1_q;
  logic              adv_d1_q, adv_d1_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] avail_q, avail_d;

  logic grant_a, can_acc, acc_a, acc_b, accept, rd_ok, pop, full;

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    wr_d     = 1'b0;
    din_d    = din_q;
    frst_d   = 1'b0;
    count_d  = count_q;
    avail_d  = avail_q;

    full    = (count_q == CNT_MAX);
    // A wins when alone, or when both ask and B had the previous grant.
    grant_a = bus.a_valid && (!bus.b_valid || last_b_q);
    can_acc = rst_n && (state_q == RUN) && !full && !bus.flush_req;
    acc_a   = can_acc && grant_a;
    acc_b   = can_acc && bus.b_valid && !grant_a;
    accept  = acc_a || acc_b;

    rd_ok    = (state_q == RUN) && (avail_q != '0) && !adv_d1_q;
    pop      = rd_ok && bus.rd_req;
    adv_d1_d = pop;

    if (accept) begin
      wr_d     = 1'b1;
      din_d    = acc_a ? bus.a_data : bus.b_data;
      last_b_d = acc_b;
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    case ({wr_d1_q, pop})
      2'b10:   avail_d = avail_q + CNT_ONE;
      2'b01:   avail_d = avail_q - CNT_ONE;
      default: avail_d = avail_q;
    endcase

    case (state_q)
      RUN: begin
        if (bus.flush_req) begin
          state_d = FLUSH;
          frst_d  = 1'b1;
        end
      end
      FLUSH: begin
        state_d  = SETTLE;
        count_d  = '0;
        avail_d  = '0;
        adv_d1_d = 1'b0;
      end
      SETTLE:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      last_b_q <= 1'b1;
      wr_q     <= 1'b0;
      din_q    <= '0;
      frst_q   <= 1'b0;
      wr_d1_q  <= 1'b0;
      adv_d1_q <= 1'b0;
      count_q  <= '0;
      avail_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      wr_q     <= wr_d;
      din_q    <= din_d;
      frst_q   <= frst_d;
      wr_d1_q  <= wr_q;
      adv_d1_q <= adv_d1_d;
      count_q  <= count_d;
      avail_q  <= avail_d;
    end
  end

  assign bus.a_ready    = acc_a;
  assign bus.b_ready    = acc_b;
  assign bus.rd_valid   = rd_ok;
  assign bus.fifo_adv   = pop;
  assign bus.flush_busy = (state_q != RUN);
  assign bus.fifo_write = wr_q;
  assign bus.fifo_din   = din_q;
  assign bus.fifo_rst   = frst_q;
  assign bus.count      = count_q;
  assign bus.full       = full;
  assign bus.empty      = (count_q == '0);
endmodule

// File: tb/tb_fifo_port_sched.sv
// Directed bench for fifo_port_sched with a behavioural Fifo model and write/pop scoreboards.
module tb_fifo_port_sched;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 13;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fifo_port_sched_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();
  fifo_port_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [DATA_W-1:0] wq[$];
  logic [DATA_W-1:0] rq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // External Fifo: single write port, registered data_out, one-cycle reload after advance.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] in_ptr  = '0;
  logic [ADDR_W-1:0] out_ptr = '0;
  logic [DATA_W-1:0] dout;
  always @(posedge clk) begin
    if (bus.fifo_rst) begin
      in_ptr  <= '0;
      out_ptr <= '0;
    end else begin
      if (bus.fifo_write) begin
        mem[in_ptr] <= bus.fifo_din;
        in_ptr      <= in_ptr + 1'b1;
      end
      if (bus.fifo_adv) out_ptr <= out_ptr + 1'b1;
    end
    dout <= mem[out_ptr];
  end

  logic [DATA_W-1:0] mon_e;
  always @(negedge clk) begin
    if (bus.fifo_write) begin
      if (wq.size() == 0) chk("write_queue", bus.fifo_write, 0);
      else begin
        mon_e = wq.pop_front();
        chk("fifo_din", bus.fifo_din, mon_e);
        rq.push_back(mon_e);
      end
    end
    if (bus.fifo_adv) begin
      if (rq.size() == 0) chk("pop_queue", bus.fifo_adv, 0);
      else begin
        mon_e = rq.pop_front();
        chk("pop_data", dout, mon_e);
      end
    end
    if (bus.a_valid && bus.b_valid) chk("single_grant", bus.a_ready && bus.b_ready, 0);
  end

  task automatic check_idle(input string tag);
    chk({tag, "_a_ready"}, bus.a_ready, 0);
    chk({tag, "_b_ready"}, bus.b_ready, 0);
    chk({tag, "_rd_valid"}, bus.rd_valid, 0);
    chk({tag, "_flush_busy"}, bus.flush_busy, 0);
    chk({tag, "_fifo_write"}, bus.fifo_write, 0);
    chk({tag, "_fifo_din"}, bus.fifo_din, 0);
    chk({tag, "_fifo_adv"}, bus.fifo_adv, 0);
    chk({tag, "_fifo_rst"}, bus.fifo_rst, 0);
    chk({tag, "_count"}, bus.count, 0);
    chk({tag, "_full"}, bus.full, 0);
    chk({tag, "_empty"}, bus.empty, 1);
  endtask

  task automatic drain(input string tag, input int budget);
    bit done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(posedge clk); #1;
      bus.rd_req = 1'b1;
      @(negedge clk);
      if (bus.empty && wq.size() == 0 && rq.size() == 0) done = 1'b1;
    end
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    chk({tag, "_drain_empty"}, bus.empty, 1);
    chk({tag, "_drain_count"}, bus.count, 0);
    chk({tag, "_drain_scoreboard"}, wq.size() + rq.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    bit lg_b;
    bit ga;
    int ia, ib;

    bus.a_valid = 1'b0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_data = '0;
    bus.rd_req  = 1'b0; bus.flush_req = 1'b0;
    #2;
    check_idle("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // A only: two words, popped back in order
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      bus.a_valid = (k < 2);
      bus.a_data  = (k == 0) ? 12'h123 : 12'h456;
      bus.rd_req  = (k >= 3);
      if (k < 2) wq.push_back(bus.a_data);
      @(negedge clk);
      if (k < 2) chk("t1_a_ready", bus.a_ready, 1);
      chk("t1_fifo_write", bus.fifo_write, (k == 1 || k == 2));
      chk("t1_rd_valid", bus.rd_valid, (k == 3 || k == 5));
    end
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("t1_empty", bus.empty, 1);
    chk("t1_scoreboard", rq.size(), 0);

    // Both requesters valid, starting from last_grant=B
    do_reset();
    lg_b = 1'b1; ia = 0; ib = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      ga = lg_b;
      bus.a_valid = 1'b1; bus.a_data = 12'hA00 + 12'(ia);
      bus.b_valid = 1'b1; bus.b_data = 12'hB00 + 12'(ib);
      wq.push_back(ga ? bus.a_data : bus.b_data);
      @(negedge clk);
      chk("t2_a_ready", bus.a_ready, ga);
      chk("t2_b_ready", bus.b_ready, !ga);
      if (ga) ia++; else ib++;
      lg_b = !ga;
    end
    @(posedge clk); #1;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    @(negedge clk);
    chk("t2_count", bus.count, 4);
    drain("t2", 40);

    // Fill to capacity, one pop reopens exactly one slot
    for (int i = 0; i < (1 << ADDR_W) - 1; i++) begin
      @(posedge clk); #1;
      bus.a_valid = 1'b1; bus.a_data = 12'(i * 7);
      wq.push_back(bus.a_data);
      @(negedge clk);
      chk("t3_fill_ready", bus.a_ready, 1);
    end
    @(posedge clk); #1;
    bus.a_data = 12'h777; bus.b_valid = 1'b1; bus.b_data = 12'h888; bus.rd_req = 1'b1;
    @(negedge clk);
    chk("t3_full", bus.full, 1);
    chk("t3_full_a_ready", bus.a_ready, 0);
    chk("t3_full_b_ready", bus.b_ready, 0);
    chk("t3_full_adv", bus.fifo_adv, 1);
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    wq.push_back(12'h888);
    @(negedge clk);
    chk("t3_reopen_full", bus.full, 0);
    chk("t3_reopen_count", bus.count, 8190);
    chk("t3_reopen_a_ready", bus.a_ready, 0);
    chk("t3_reopen_b_ready", bus.b_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_refull", bus.full, 1);
    chk("t3_refull_b_ready", bus.b_ready, 0);
    @(posedge clk); #1;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    drain("t3", 20000);

    // rd_req held high over three words: pops every other cycle
    for (int k = 0; k < 11; k++) begin
      @(posedge clk); #1;
      bus.a_valid = (k < 3); bus.a_data = 12'h400 + 12'(k);
      bus.rd_req  = 1'b1;
      if (k < 3) wq.push_back(bus.a_data);
      @(negedge clk);
      chk("t4_fifo_adv", bus.fifo_adv, (k == 3 || k == 5 || k == 7));
      if (k == 4) chk("t4_count_mid", bus.count, 2);
      if (k == 8) chk("t4_count_end", bus.count, 0);
    end
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("t4_empty", bus.empty, 1);

    // Flush while A streams
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      bus.a_valid   = (k < 6); bus.a_data = 12'h500 + 12'(k);
      bus.flush_req = (k == 3);
      if (k < 3) wq.push_back(bus.a_data);
      @(negedge clk);
      chk("t5_a_ready", bus.a_ready, (k < 3));
      chk("t5_fifo_rst", bus.fifo_rst, (k == 4));
      chk("t5_flush_busy", bus.flush_busy, (k == 4 || k == 5));
      if (k == 4) chk("t5_write_blocked", bus.fifo_write, 0);
      if (k >= 4) chk("t5_rd_valid", bus.rd_valid, 0);
      if (k >= 6) chk("t5_count", bus.count, 0);
    end
    rq.delete();
    @(posedge clk); #1;
    bus.a_valid = 1'b1; bus.a_data = 12'hABC;
    wq.push_back(12'hABC);
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    drain("t5", 20);

    // Asynchronous reset in the middle of a stream
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus.a_valid = 1'b1; bus.a_data = 12'h600 + 12'(k);
      wq.push_back(bus.a_data);
      @(negedge clk);
      chk("t6_a_ready", bus.a_ready, 1);
    end
    @(posedge clk); #1;
    bus.b_valid = 1'b1; bus.b_data = 12'h6B0;
    #1;
    rst_n = 1'b0;
    #1;
    check_idle("t6_reset");
    @(negedge clk);
    wq.delete();
    rq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    @(negedge clk);
    chk("t6_empty", bus.empty, 1);
    chk("t6_count", bus.count, 0);
    @(posedge clk); #1;
    bus.flush_req = 1'b1;
    @(posedge clk); #1;
    bus.flush_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.a_valid = 1'b1; bus.a_data = 12'h6A0;
    bus.b_valid = 1'b1; bus.b_data = 12'h6B0;
    wq.push_back(12'h6A0);
    @(negedge clk);
    chk("t6_grant_a", bus.a_ready, 1);
    chk("t6_grant_b", bus.b_ready, 0);
    @(posedge clk); #1;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    drain("t6", 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
